// File: rtl/ws28xx_dec_if.sv
// ----------------------------------------------------------------------------
// ws28xx_dec_if
// Output bundle of the WS28xx code decoder.
//   master : driven by the decoder
//   slave  : observed by the consumer (LED chain, loopback checker, monitor)
// Signals:
//   bit_data_o   decoded bit, meaningful while bit_valid_o is high
//   bit_valid_o  one-cycle pulse per decoded bit
//   word_data_o  last assembled word, MSB = first received bit, held
//   word_valid_o one-cycle pulse when a full word has been collected
//   frame_rst_o  one-cycle pulse on a latch/reset gap
//   code_err_o   one-cycle pulse on an over-long high pulse
// ----------------------------------------------------------------------------
interface ws28xx_dec_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  bit_data_o;
  logic                  bit_valid_o;
  logic [DATA_WIDTH-1:0] word_data_o;
  logic                  word_valid_o;
  logic                  frame_rst_o;
  logic                  code_err_o;

  modport master (
    output bit_data_o, bit_valid_o, word_data_o, word_valid_o, frame_rst_o, code_err_o
  );

  modport slave (
    input bit_data_o, bit_valid_o, word_data_o, word_valid_o, frame_rst_o, code_err_o
  );
endinterface

// File: rtl/ws28xx_dec.sv
// ----------------------------------------------------------------------------
// ws28xx_dec
// Single-wire WS28xx code decoder. The asynchronous code line is
// synchronised, every high pulse is classified as 0/1 by comparing its high
// time with a threshold, and bits are packed MSB-first into DATA_WIDTH-bit
// words. A long low gap is reported as a frame reset (partial word dropped),
// and a high pulse reaching 511 clocks is reported as a code error.
// Ports:
//   clk_i           clock
//   rst_n_i         asynchronous active-low reset
//   bit_code_i      asynchronous serial code line
//   reg_thr_time_i  high-time threshold; high time > threshold decodes as 1
//   reg_rst_time_i  low time that forms a reset gap; 0 disables detection
//   dec_o           decoded bit / word / event outputs (master modport)
// ----------------------------------------------------------------------------
module ws28xx_dec #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 24
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         bit_code_i,
  input  logic [7:0]   reg_thr_time_i,
  input  logic [15:0]  reg_rst_time_i,
  ws28xx_dec_if.master dec_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int               IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [8:0]       HI_MAX   = 9'h1FF;
  localparam logic [15:0]      LO_MAX   = 16'hFFFF;

  // Input synchroniser; only its last stage is ever looked at.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   code_s;

  // Decoder state
  state_e                 state_q, state_d;
  logic [8:0]             hi_cnt_q, hi_cnt_d;
  logic [15:0]            lo_cnt_q, lo_cnt_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;

  // Decision stage: events computed by the FSM on the cycle it sees the fall.
  logic                   evt_bit_valid_q, evt_bit_valid_d;
  logic                   evt_bit_data_q, evt_bit_data_d;
  logic                   evt_word_valid_q, evt_word_valid_d;
  logic                   evt_frame_q, evt_frame_d;
  logic                   evt_err_q, evt_err_d;
  logic [DATA_WIDTH-1:0]  word_hold_q, word_hold_d;

  // Output stage: one more register after the decision so a bit appears
  // SYNC_STAGES+1 clocks after its falling edge is first sampled.
  logic                   bit_valid_q, bit_data_q, word_valid_q, frame_rst_q, code_err_q;
  logic [DATA_WIDTH-1:0]  word_data_q;

  // Classification and shifted word for the pulse currently ending.
  logic                   dec_bit;
  logic [DATA_WIDTH:0]    shifted;

  assign code_s  = sync_q[SYNC_STAGES-1];
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], bit_code_i};
  assign dec_bit = (hi_cnt_q > {1'b0, reg_thr_time_i});
  assign shifted = {shreg_q, dec_bit};

  // NOTE: every variable gets its default at the top of the block so no path
  // leaves one unassigned; a missed assignment here would infer a latch.
  always_comb begin
    state_d          = state_q;
    hi_cnt_d         = hi_cnt_q;
    lo_cnt_d         = lo_cnt_q;
    bit_idx_d        = bit_idx_q;
    shreg_d          = shreg_q;
    word_hold_d      = word_hold_q;
    evt_bit_data_d   = evt_bit_data_q;
    evt_bit_valid_d  = 1'b0;
    evt_word_valid_d = 1'b0;
    evt_frame_d      = 1'b0;
    evt_err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (code_s) begin
          state_d  = HIGH;
          hi_cnt_d = 9'd1;
        end
      end

      HIGH: begin
        if (code_s) begin
          if (hi_cnt_q == HI_MAX - 9'd1) begin
            // Line stuck high: flag once, drop the partial word and wait
            // for the line to fall without emitting a bit.
            hi_cnt_d  = HI_MAX;
            evt_err_d = 1'b1;
            shreg_d   = '0;
            bit_idx_d = '0;
            state_d   = HOLD;
          end else begin
            hi_cnt_d = hi_cnt_q + 9'd1;
          end
        end else begin
          evt_bit_valid_d = 1'b1;
          evt_bit_data_d  = dec_bit;
          shreg_d         = shifted[DATA_WIDTH-1:0];
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d        = '0;
            evt_word_valid_d = 1'b1;
            word_hold_d      = shifted[DATA_WIDTH-1:0];
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
          state_d  = LOW;
          lo_cnt_d = 16'd1;
        end
      end

      LOW: begin
        if (code_s) begin
          state_d  = HIGH;
          hi_cnt_d = 9'd1;
        end else begin
          if (lo_cnt_q != LO_MAX) begin
            lo_cnt_d = lo_cnt_q + 16'd1;
          end
          if ((reg_rst_time_i != 16'd0) && (lo_cnt_q == reg_rst_time_i)) begin
            evt_frame_d = 1'b1;
            shreg_d     = '0;
            bit_idx_d   = '0;
            state_d     = IDLE;
          end
        end
      end

      HOLD: begin
        if (!code_s) begin
          state_d  = LOW;
          lo_cnt_d = 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q           <= '0;
      state_q          <= IDLE;
      hi_cnt_q         <= '0;
      lo_cnt_q         <= '0;
      bit_idx_q        <= '0;
      shreg_q          <= '0;
      word_hold_q      <= '0;
      evt_bit_valid_q  <= 1'b0;
      evt_bit_data_q   <= 1'b0;
      evt_word_valid_q <= 1'b0;
      evt_frame_q      <= 1'b0;
      evt_err_q        <= 1'b0;
      bit_valid_q      <= 1'b0;
      bit_data_q       <= 1'b0;
      word_valid_q     <= 1'b0;
      frame_rst_q      <= 1'b0;
      code_err_q       <= 1'b0;
      word_data_q      <= '0;
    end else begin
      sync_q           <= sync_d;
      state_q          <= state_d;
      hi_cnt_q         <= hi_cnt_d;
      lo_cnt_q         <= lo_cnt_d;
      bit_idx_q        <= bit_idx_d;
      shreg_q          <= shreg_d;
      word_hold_q      <= word_hold_d;
      evt_bit_valid_q  <= evt_bit_valid_d;
      evt_bit_data_q   <= evt_bit_data_d;
      evt_word_valid_q <= evt_word_valid_d;
      evt_frame_q      <= evt_frame_d;
      evt_err_q        <= evt_err_d;
      bit_valid_q      <= evt_bit_valid_q;
      bit_data_q       <= evt_bit_data_q;
      word_valid_q     <= evt_word_valid_q;
      frame_rst_q      <= evt_frame_q;
      code_err_q       <= evt_err_q;
      // word_hold_q only changes on word completion, so the output word
      // updates on the same edge that raises word_valid_o.
      word_data_q      <= word_hold_q;
    end
  end

  assign dec_o.bit_data_o   = bit_data_q;
  assign dec_o.bit_valid_o  = bit_valid_q;
  assign dec_o.word_data_o  = word_data_q;
  assign dec_o.word_valid_o = word_valid_q;
  assign dec_o.frame_rst_o  = frame_rst_q;
  assign dec_o.code_err_o   = code_err_q;

endmodule

// File: tb/tb_ws28xx_dec.sv
// ----------------------------------------------------------------------------
// tb_ws28xx_dec
// Directed bench for ws28xx_dec (DATA_WIDTH=24, SYNC_STAGES=2, thr=30,
// reset gap 2500). A negedge monitor counts output events; directed
// sequences compare count deltas and captured values with hand-derived ones.
// ----------------------------------------------------------------------------
module tb_ws28xx_dec;

  localparam int DW = 24;

  logic        clk;
  logic        rst_n;
  logic        code;
  logic [7:0]  thr;
  logic [15:0] rst_time;

  ws28xx_dec_if #(.DATA_WIDTH(DW)) dec_if ();

  ws28xx_dec #(
    .SYNC_STAGES (2),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .bit_code_i     (code),
    .reg_thr_time_i (thr),
    .reg_rst_time_i (rst_time),
    .dec_o          (dec_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitor, sampled on the falling edge.
  int          n_bits      = 0;
  int          n_words     = 0;
  int          n_frame     = 0;
  int          n_err       = 0;
  int          n_excl      = 0;
  int          n_coinc_bad = 0;
  int          bits_at_word = 0;
  logic        last_bit    = 1'b0;
  logic [31:0] last_word   = 32'h0;

  always @(negedge clk) begin
    if (dec_if.bit_valid_o) begin
      n_bits   = n_bits + 1;
      last_bit = dec_if.bit_data_o;
    end
    if (dec_if.word_valid_o) begin
      n_words      = n_words + 1;
      last_word    = 32'(dec_if.word_data_o);
      bits_at_word = n_bits;
      if (!dec_if.bit_valid_o) n_coinc_bad = n_coinc_bad + 1;
    end
    if (dec_if.frame_rst_o) n_frame = n_frame + 1;
    if (dec_if.code_err_o)  n_err   = n_err + 1;
    if ((int'(dec_if.bit_valid_o) + int'(dec_if.frame_rst_o) + int'(dec_if.code_err_o)) > 1)
      n_excl = n_excl + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return {3'b0, dec_if.bit_data_o, dec_if.bit_valid_o, dec_if.word_valid_o,
            dec_if.frame_rst_o, dec_if.code_err_o, dec_if.word_data_o};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pulse(input int hi, input int lo);
    code = 1'b1;
    wait_clks(hi);
    code = 1'b0;
    wait_clks(lo);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(40, 23);
    else   send_pulse(18, 45);
  endtask

  // Sends the top n bits of a 24-bit value, MSB first.
  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = DW - 1; i >= DW - n; i--) send_bit(w[i]);
  endtask

  task automatic send_word_and_check(input string tag, input logic [31:0] w);
    int b0, w0;
    b0 = n_bits;
    w0 = n_words;
    send_bits(w, DW);
    check({tag, "_bits"},  32'(n_bits - b0), 32'd24);
    check({tag, "_words"}, 32'(n_words - w0), 32'd1);
    check({tag, "_data"},  last_word, w);
  endtask

  initial begin
    int b0, w0, f0, e0, lat;

    rst_n    = 1'b0;
    code     = 1'b0;
    thr      = 8'd30;
    rst_time = 16'd2500;

    wait_clks(3);
    check("reset_outputs", all_outputs(), 32'h0);
    rst_n = 1'b1;
    wait_clks(5);
    check("idle_outputs", all_outputs(), 32'h0);

    // Single 0 bit and its latency from the first sampling edge of the fall.
    b0 = n_bits; w0 = n_words;
    code = 1'b1;
    wait_clks(18);
    code = 1'b0;
    lat  = 0;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (dec_if.bit_valid_o && lat == 0) lat = n;
    end
    wait_clks(35);
    check("single_latency", 32'(lat), 32'd3);
    check("single_bits",    32'(n_bits - b0), 32'd1);
    check("single_value",   {31'b0, last_bit}, 32'd0);
    check("single_no_word", 32'(n_words - w0), 32'd0);

    // Flush the lone bit with a gap so the next word starts aligned.
    f0 = n_frame;
    wait_clks(2600);
    check("flush_gap_frame", 32'(n_frame - f0), 32'd1);

    // Full word; word_valid must land with the 24th bit pulse.
    b0 = n_bits;
    send_word_and_check("word_a5c3f0", 32'hA5C3F0);
    check("word_coincident", 32'(n_coinc_bad), 32'd0);
    check("word_at_bit24",   32'(bits_at_word - b0), 32'd24);

    // Reset gap after 10 bits discards the partial word.
    f0 = n_frame; w0 = n_words;
    send_bits(32'hB3C000, 10);
    wait_clks(2500);
    check("gap_frame_once", 32'(n_frame - f0), 32'd1);
    check("gap_no_word",    32'(n_words - w0), 32'd0);
    send_word_and_check("word_000001", 32'h000001);

    // Threshold edges.
    b0 = n_bits;
    send_pulse(30, 45);
    check("thr_eq_value", {31'b0, last_bit}, 32'd0);
    send_pulse(31, 45);
    check("thr_p1_value", {31'b0, last_bit}, 32'd1);
    send_pulse(1, 45);
    check("glitch_value", {31'b0, last_bit}, 32'd0);
    check("thr_bits", 32'(n_bits - b0), 32'd3);

    // Gap detection disabled: a very long low yields no frame reset.
    f0 = n_frame;
    rst_time = 16'd0;
    wait_clks(70000);
    check("disabled_gap", 32'(n_frame - f0), 32'd0);
    rst_time = 16'd2500;

    // Stuck high: one code error, no bit; then a clean word.
    b0 = n_bits; e0 = n_err;
    code = 1'b1;
    wait_clks(600);
    check("stuck_err_once", 32'(n_err - e0), 32'd1);
    check("stuck_no_bit",   32'(n_bits - b0), 32'd0);
    code = 1'b0;
    wait_clks(45);
    send_word_and_check("word_after_err", 32'h5A0FC3);

    // Async reset in the middle of the 13th bit's high time.
    send_bits(32'h123456, 12);
    code = 1'b1;
    wait_clks(10);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outputs(), 32'h0);
    code = 1'b0;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(50);
    send_word_and_check("word_123456", 32'h123456);

    check("mutual_exclusion", 32'(n_excl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
